// File: rtl/cash_accumulator.sv
// Coin/bill acceptor front end: sync, debounce and edge-detect each channel,
// then commit one refund, spend or credit per cycle into a saturating total.
module cash_accumulator #(
  parameter int NUM_CH = 6,
  parameter int VAL_W = 8,
  parameter logic [NUM_CH*VAL_W-1:0] DENOM_VALUES =
    {8'd100, 8'd50, 8'd20, 8'd10, 8'd5, 8'd1},
  parameter int SUM_W = 12,
  parameter int MAX_SUM = 4095,
  parameter int DEBOUNCE_CYC = 4,
  parameter int LED_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] cash_Input,
  input  logic              spend_valid,
  input  logic [SUM_W-1:0]  spend_amount,
  input  logic              refund_req,
  output logic [SUM_W-1:0]  currency,
  output logic [NUM_CH-1:0] cash_led,
  output logic              coin_reject,
  output logic              spend_ack,
  output logic              spend_nack,
  output logic              refund_valid,
  output logic [SUM_W-1:0]  refund_amount
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int LED_W = $clog2(LED_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_HOLD);
  localparam logic [SUM_W:0] MAX_EXT = (SUM_W + 1)'(MAX_SUM);

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] deb;
  logic [NUM_CH-1:0] deb_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pending;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [LED_W-1:0]  timer [NUM_CH];

  logic              sel_hit;
  logic [NUM_CH-1:0] sel_oh;
  logic [VAL_W-1:0]  sel_val;
  logic [SUM_W:0]    sum_ext;
  logic              fits;

  logic [SUM_W-1:0]  cur_next;
  logic [SUM_W-1:0]  ra_next;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] credit_oh;
  logic              ack_next;
  logic              nack_next;
  logic              rej_next;
  logic              rv_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < NUM_CH; i++)
        cnt[i] <= '0;
    end else begin
      sync1 <= cash_Input;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          deb[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb & ~deb_q;

  // Lowest pending index wins: scan downward so the last hit sticks.
  always_comb begin
    sel_hit = 1'b0;
    sel_oh  = '0;
    sel_val = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_hit   = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_val   = DENOM_VALUES[i*VAL_W +: VAL_W];
      end
    end
  end

  assign sum_ext = {1'b0, currency} + (SUM_W + 1)'(sel_val);
  assign fits    = sum_ext <= MAX_EXT;

  always_comb begin
    cur_next  = currency;
    ra_next   = '0;
    clr       = '0;
    credit_oh = '0;
    ack_next  = 1'b0;
    nack_next = 1'b0;
    rej_next  = 1'b0;
    rv_next   = 1'b0;
    priority case (1'b1)
      refund_req: begin
        rv_next  = 1'b1;
        ra_next  = currency;
        cur_next = '0;
      end
      spend_valid: begin
        if (spend_amount <= currency) begin
          ack_next = 1'b1;
          cur_next = currency - spend_amount;
        end else begin
          nack_next = 1'b1;
        end
      end
      sel_hit: begin
        clr = sel_oh;
        if (fits) begin
          cur_next  = sum_ext[SUM_W-1:0];
          credit_oh = sel_oh;
        end else begin
          rej_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      currency      <= '0;
      refund_amount <= '0;
      pending       <= '0;
      spend_ack     <= 1'b0;
      spend_nack    <= 1'b0;
      coin_reject   <= 1'b0;
      refund_valid  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        timer[i] <= '0;
    end else begin
      currency      <= cur_next;
      refund_amount <= ra_next;
      pending       <= (pending & ~clr) | rise;
      spend_ack     <= ack_next;
      spend_nack    <= nack_next;
      coin_reject   <= rej_next;
      refund_valid  <= rv_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (credit_oh[i])
          timer[i] <= LED_LOAD;
        else if (timer[i] != '0)
          timer[i] <= timer[i] - 1'b1;
      end
    end
  end

  always_comb begin
    cash_led = '0;
    for (int i = 0; i < NUM_CH; i++)
      cash_led[i] = timer[i] != '0;
  end

endmodule

// File: tb/tb_cash_accumulator.sv
// Bench for cash_accumulator: directed scenarios plus random traffic,
// all checked against a window-based behavioural model.
module tb_cash_accumulator;

  localparam int NUM_CH = 6;
  localparam int SUM_W = 12;
  localparam int MAX_SUM = 4095;
  localparam int D = 4;
  localparam int LH = 8;
  localparam int DEN[NUM_CH] = '{1, 5, 10, 20, 50, 100};

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] cash_Input;
  logic              spend_valid;
  logic [SUM_W-1:0]  spend_amount;
  logic              refund_req;
  logic [SUM_W-1:0]  currency;
  logic [NUM_CH-1:0] cash_led;
  logic              coin_reject;
  logic              spend_ack;
  logic              spend_nack;
  logic              refund_valid;
  logic [SUM_W-1:0]  refund_amount;

  always #5 clk = ~clk;

  cash_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .cash_Input    (cash_Input),
    .spend_valid   (spend_valid),
    .spend_amount  (spend_amount),
    .refund_req    (refund_req),
    .currency      (currency),
    .cash_led      (cash_led),
    .coin_reject   (coin_reject),
    .spend_ack     (spend_ack),
    .spend_nack    (spend_nack),
    .refund_valid  (refund_valid),
    .refund_amount (refund_amount)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rej_seen = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int m_cur;
  int m_tmr[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_deb[NUM_CH];
  bit m_debq[NUM_CH];
  bit m_s1[NUM_CH];
  bit m_s2[NUM_CH];
  bit m_hist[NUM_CH][$];
  int e_ack, e_nack, e_rej, e_rv, e_ra;

  task automatic model_step();
    int ci;
    int cred;
    bit rise;
    bit flip;
    e_ack = 0; e_nack = 0; e_rej = 0; e_rv = 0; e_ra = 0;
    if (!rst) begin
      m_cur = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_tmr[i] = 0; m_pend[i] = 0; m_deb[i] = 0;
        m_debq[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        m_hist[i].delete();
      end
      return;
    end
    ci = -1;
    cred = -1;
    if (refund_req) begin
      e_rv = 1; e_ra = m_cur; m_cur = 0;
    end else if (spend_valid) begin
      if (int'(spend_amount) <= m_cur) begin
        e_ack = 1; m_cur -= int'(spend_amount);
      end else begin
        e_nack = 1;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (m_pend[i]) begin ci = i; break; end
      if (ci >= 0) begin
        m_pend[ci] = 0;
        if (m_cur + DEN[ci] <= MAX_SUM) begin
          m_cur += DEN[ci]; cred = ci;
        end else begin
          e_rej = 1;
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (i == cred) m_tmr[i] = LH;
      else if (m_tmr[i] > 0) m_tmr[i]--;
      rise = m_deb[i] && !m_debq[i];
      if (rise) m_pend[i] = 1;
      m_debq[i] = m_deb[i];
      // level changes once the last D synchronised samples all disagree
      m_hist[i].push_back(m_s2[i]);
      if (m_hist[i].size() > D) void'(m_hist[i].pop_front());
      flip = (m_hist[i].size() == D);
      foreach (m_hist[i][k])
        if (m_hist[i][k] == m_deb[i]) flip = 0;
      if (flip) m_deb[i] = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = cash_Input[i];
    end
  endtask

  task automatic compare();
    logic [NUM_CH-1:0] el;
    for (int i = 0; i < NUM_CH; i++) el[i] = m_tmr[i] != 0;
    chk("currency", currency, m_cur);
    chk("cash_led", cash_led, el);
    chk("coin_reject", coin_reject, e_rej);
    chk("spend_ack", spend_ack, e_ack);
    chk("spend_nack", spend_nack, e_nack);
    chk("refund_valid", refund_valid, e_rv);
    chk("refund_amount", refund_amount, e_ra);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
    rej_seen += int'(coin_reject);
  endtask

  task automatic insert(input int ch);
    cash_Input[ch] = 1'b1;
    repeat (D + 4) tick();
    cash_Input[ch] = 1'b0;
    repeat (D + 4) tick();
  endtask

  task automatic do_refund();
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cash_Input = '0;
    spend_valid = 1'b0;
    spend_amount = '0;
    refund_req = 1'b0;
    repeat (3) tick();
    chk("rst_currency", currency, 0);
    chk("rst_led", cash_led, 0);
    chk("rst_pulses",
        {coin_reject, spend_ack, spend_nack, refund_valid}, 0);
    chk("rst_refund_amount", refund_amount, 0);
    rst = 1'b1;
    repeat (5) tick();

    cash_Input[2] = 1'b1;
    repeat (3) tick();
    cash_Input[2] = 1'b0;
    repeat (15) tick();
    chk("glitch3", currency, 0);
    cash_Input[2] = 1'b1;
    repeat (10) tick();
    cash_Input[2] = 1'b0;
    repeat (15) tick();
    chk("pulse10", currency, 10);
    do_refund();
    chk("refund10_amt", refund_amount, 10);
    chk("refund10_cur", currency, 0);
    repeat (5) tick();

    cash_Input = 6'b110001;
    repeat (D + 3) tick();
    chk("latency_pre", currency, 0);
    tick();
    chk("step1", currency, 1);
    tick();
    chk("step51", currency, 51);
    tick();
    chk("step151", currency, 151);
    chk("led_all", cash_led, 6'b110001);
    repeat (6) tick();
    chk("led_ch0_off", cash_led, 6'b110000);
    tick();
    chk("led_ch4_off", cash_led, 6'b100000);
    tick();
    chk("led_ch5_off", cash_led, 6'b000000);
    cash_Input = '0;
    repeat (12) tick();

    spend_valid = 1'b1;
    spend_amount = 12'd151;
    tick();
    chk("spend151_ack", spend_ack, 1);
    chk("spend151_cur", currency, 0);
    spend_amount = 12'd10;
    tick();
    spend_valid = 1'b0;
    chk("spend10_nack", spend_nack, 1);
    chk("spend10_ack", spend_ack, 0);
    chk("spend10_cur", currency, 0);

    repeat (40) insert(5);
    insert(4);
    chk("fill4050", currency, 4050);
    rej_seen = 0;
    insert(5);
    chk("ovf_reject", rej_seen, 1);
    chk("ovf_cur", currency, 4050);
    rej_seen = 0;
    insert(3);
    chk("after_ovf_cur", currency, 4070);
    chk("after_ovf_reject", rej_seen, 0);
    do_refund();
    chk("refund4070", refund_amount, 4070);

    insert(4);
    insert(2);
    chk("load60", currency, 60);
    cash_Input[1] = 1'b1;
    repeat (D + 3) tick();
    do_refund();
    chk("refund60_valid", refund_valid, 1);
    chk("refund60_amt", refund_amount, 60);
    chk("refund60_cur", currency, 0);
    tick();
    chk("post_refund_credit", currency, 5);
    cash_Input = '0;
    repeat (12) tick();
    do_refund();

    cash_Input = 6'b001010;
    repeat (D + 3) tick();
    rst = 1'b0;
    cash_Input = '0;
    tick();
    chk("midrst_cur", currency, 0);
    chk("midrst_led", cash_led, 0);
    chk("midrst_pulses",
        {coin_reject, spend_ack, spend_nack, refund_valid}, 0);
    rst = 1'b1;
    repeat (20) tick();
    chk("midrst_dropped", currency, 0);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 15) == 0) cash_Input[i] = ~cash_Input[i];
      spend_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        spend_amount = SUM_W'($urandom_range(0, 4095));
      else
        spend_amount = SUM_W'($urandom_range(0, m_cur + 30));
      refund_req = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst = 1'b1;
    spend_valid = 1'b0;
    refund_req = 1'b0;
    cash_Input = '0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
